// File: rtl/lift_pkg.sv
// Shared constants and enums for the lift call scheduler.
// Optional press debounce is enabled with LIFT_CALL_DEBOUNCE_EN.
package lift_pkg;

    localparam int FLOOR_W    = 2;
    localparam int NUM_FLOORS = 1 << FLOOR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVING,
        ST_DOOR
    } state_e;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_e;

endpackage

// File: rtl/lift_btn_sync.sv
// Per-floor call button edge detector; one-cycle rise pulse per press.
// With LIFT_CALL_DEBOUNCE_EN the level must be stable for DEBOUNCE_CYCLES samples.
module lift_btn_sync
`ifdef LIFT_CALL_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

`ifdef LIFT_CALL_DEBOUNCE_EN
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Saturating count of consecutive high samples; a low sample restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if (!btn) begin
            cnt_d = '0;
        end else if (cnt_q != 8'(DEBOUNCE_CYCLES)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign rise = btn && (cnt_q == 8'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic hist_q;
    logic hist_d;

    assign hist_d = btn;
    assign rise   = btn & ~hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end
`endif

endmodule

// File: rtl/lift_call_scheduler.sv
// SCAN call scheduler: latches floor calls, issues one target at a time, runs door dwell.
// Press debounce is optional via LIFT_CALL_DEBOUNCE_EN.
module lift_call_scheduler #(
    parameter int FLOOR_W         = lift_pkg::FLOOR_W,
    parameter int NUM_FLOORS      = 1 << FLOOR_W,
    parameter int DWELL_CYCLES    = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  motor_up,
    input  logic                  motor_down,
    output logic [FLOOR_W-1:0]    floor_button,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  busy
);
    import lift_pkg::*;

    if (DWELL_CYCLES < 1 || DWELL_CYCLES > 255) begin : g_bad_dwell
        $error("DWELL_CYCLES must be 1..255");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be 1..255");
    end
    if (NUM_FLOORS != (1 << FLOOR_W)) begin : g_bad_floors
        $error("NUM_FLOORS must equal 2**FLOOR_W");
    end

    localparam logic [7:0] DWELL_LD = 8'(DWELL_CYCLES);

    state_e                state_q, state_d;
    dir_e                  dir_q, dir_d;
    logic [FLOOR_W-1:0]    tgt_q, tgt_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [7:0]            dwell_q, dwell_d;

    logic [NUM_FLOORS-1:0] rise_vec;
    logic [NUM_FLOORS-1:0] set_vec;
    logic [NUM_FLOORS-1:0] clr_vec;
    logic                  above_found, below_found;
    logic [FLOOR_W-1:0]    above_idx, below_idx;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
`ifdef LIFT_CALL_DEBOUNCE_EN
        lift_btn_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
`else
        lift_btn_sync u_btn (
`endif
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (call_btn[g]),
            .rise (rise_vec[g])
        );
    end

    // Scan order makes the last hit the nearest one on each side of the car.
    always_comb begin
        above_found = 1'b0;
        above_idx   = '0;
        below_found = 1'b0;
        below_idx   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (i > int'(current_floor))) begin
                above_found = 1'b1;
                above_idx   = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (i < int'(current_floor))) begin
                below_found = 1'b1;
                below_idx   = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        tgt_d   = tgt_q;
        dwell_d = dwell_q;
        set_vec = rise_vec;
        clr_vec = '0;
        case (state_q)
            ST_IDLE: begin
                tgt_d = current_floor;
                if (pending_q[current_floor]) begin
                    clr_vec[current_floor] = 1'b1;
                    dwell_d = DWELL_LD;
                    state_d = ST_DOOR;
                end else if (|pending_q) begin
                    if (dir_q == DIR_UP) begin
                        if (above_found) begin
                            tgt_d = above_idx;
                        end else begin
                            dir_d = DIR_DOWN;
                            tgt_d = below_idx;
                        end
                    end else begin
                        if (below_found) begin
                            tgt_d = below_idx;
                        end else begin
                            dir_d = DIR_UP;
                            tgt_d = above_idx;
                        end
                    end
                    state_d = ST_MOVING;
                end
            end
            ST_MOVING: begin
                if ((current_floor == tgt_q) && !motor_up && !motor_down) begin
                    clr_vec[tgt_q] = 1'b1;
                    dwell_d = DWELL_LD;
                    state_d = ST_DOOR;
                end else if ((dir_q == DIR_UP) && above_found && (above_idx < tgt_q)) begin
                    tgt_d = above_idx;
                end else if ((dir_q == DIR_DOWN) && below_found && (below_idx > tgt_q)) begin
                    tgt_d = below_idx;
                end
            end
            ST_DOOR: begin
                // A call for the floor we are standing at just holds the door longer.
                if (rise_vec[current_floor]) begin
                    set_vec[current_floor] = 1'b0;
                    dwell_d = DWELL_LD;
                end else if (dwell_q <= 8'd1) begin
                    dwell_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    dwell_d = dwell_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pending_d = (pending_q | set_vec) & ~clr_vec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            tgt_q     <= '0;
            pending_q <= '0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            tgt_q     <= tgt_d;
            pending_q <= pending_d;
            dwell_q   <= dwell_d;
        end
    end

    assign floor_button = tgt_q;
    assign pending      = pending_q;
    assign door_open    = (state_q == ST_DOOR);
    assign busy         = (state_q != ST_IDLE);

endmodule
